// File: rtl/ql_arith_pkg.sv
// ql_arith_pkg: shared segment arithmetic for the QL $alu, counter and pipelined add/sub maps
package ql_arith_pkg;
    function automatic int ql_num_stages(input int width, input int stage_w);
        return (width + stage_w - 1) / stage_w;
    endfunction
    function automatic int ql_seg_lo(input int k, input int stage_w);
        return k * stage_w;
    endfunction
    function automatic int ql_seg_hi(input int k, input int width, input int stage_w);
        return (((k + 1) * stage_w < width) ? (k + 1) * stage_w : width) - 1;
    endfunction
endpackage

// File: rtl/ql_addsub_seg.sv
// ql_addsub_seg: one registered full_adder chain segment of the pipelined adder
module ql_addsub_seg #(
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s_q,
    output logic [SEG_W-1:0] x_q,
    output logic             co_q
);
    logic [SEG_W:0] sum;
    assign sum = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, ci};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= '0;
            x_q  <= '0;
            co_q <= 1'b0;
        end else if (en) begin
            s_q  <= sum[SEG_W-1:0];
            x_q  <= a ^ b;
            co_q <= sum[SEG_W];
        end
    end
endmodule

// File: rtl/ql_pipe_addsub.sv
// ql_pipe_addsub: valid/ready pipelined add/sub, carry chain split into STAGE_W segments
module ql_pipe_addsub
    import ql_arith_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STAGE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x,
    output logic             co,
    output logic             ov
);
    localparam int STAGES = ql_num_stages(WIDTH, STAGE_W);
    logic              en;
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  bb;
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign bb        = bi ? ~b : b;
    assign out_valid = v_q[STAGES-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_q <= '0;
        else if (en) v_q <= STAGES'({v_q, in_valid});
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = ql_seg_lo(k, STAGE_W);
        localparam int HI = ql_seg_hi(k, WIDTH, STAGE_W);
        localparam int SW = HI - LO + 1;
        localparam int IW = WIDTH - LO;
        logic [IW-1:0] a_in, b_in;
        logic          c_in, co_q;
        logic [SW-1:0] s_q, x_q;
        logic [HI:0]   y_v, x_v;
        // Operands arrive right-aligned: this stage always consumes the low SW bits
        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = bb;
            assign c_in = ci;
            assign y_v  = s_q;
            assign x_v  = x_q;
        end else begin : g_next
            logic [LO-1:0] y_lo, x_lo;
            assign a_in = g_stg[k-1].g_fwd.a_fwd;
            assign b_in = g_stg[k-1].g_fwd.b_fwd;
            assign c_in = g_stg[k-1].co_q;
            assign y_v  = {s_q, y_lo};
            assign x_v  = {x_q, x_lo};
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_lo <= '0;
                    x_lo <= '0;
                end else if (en) begin
                    y_lo <= g_stg[k-1].y_v;
                    x_lo <= g_stg[k-1].x_v;
                end
            end
        end
        if (k < STAGES - 1) begin : g_fwd
            logic [IW-SW-1:0] a_fwd, b_fwd;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_fwd <= '0;
                    b_fwd <= '0;
                end else if (en) begin
                    a_fwd <= a_in[IW-1:SW];
                    b_fwd <= b_in[IW-1:SW];
                end
            end
        end
        ql_addsub_seg #(.SEG_W(SW)) u_seg (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .a    (a_in[SW-1:0]),
            .b    (b_in[SW-1:0]),
            .ci   (c_in),
            .s_q  (s_q),
            .x_q  (x_q),
            .co_q (co_q)
        );
    end
    assign y  = g_stg[STAGES-1].y_v;
    assign x  = g_stg[STAGES-1].x_v;
    assign co = g_stg[STAGES-1].co_q;
    // Carry into the MSB is recovered as sum ^ (a ^ bb) at that bit
    assign ov = y[WIDTH-1] ^ x[WIDTH-1] ^ co;
endmodule

// File: tb/tb_ql_pipe_addsub.sv
// tb_ql_pipe_addsub: scoreboard bench over three parameterisations (32/8, 13/5, 4/8)
module tb_ql_pipe_addsub;
    typedef struct {
        logic [31:0] y, x;
        logic        co, ov;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [31:0] a, b;
        logic        bi, ci;
    } stim_t;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic [2:0]  iv = '0, ir, ovl, ordy = '0, pend = '0;
    logic [31:0] da[3], db[3];
    logic [2:0]  dbi = '0, dci = '0;
    logic [31:0] y0, x0;
    logic [12:0] y1, x1;
    logic [3:0]  y2, x2;
    logic [31:0] yo[3], xo[3];
    logic [2:0]  coo, ovo;
    exp_t        sb[3][$];
    stim_t       stim[$];
    int          nvec = 0, nerr = 0, cyc = 0;
    bit          b2b = 0, hold = 0;
    logic [71:0] held;

    always #5 clk = ~clk;

    assign yo[0] = y0;
    assign xo[0] = x0;
    assign yo[1] = {19'd0, y1};
    assign xo[1] = {19'd0, x1};
    assign yo[2] = {28'd0, y2};
    assign xo[2] = {28'd0, x2};

    ql_pipe_addsub #(.WIDTH(32), .STAGE_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(da[0]), .b(db[0]),
        .bi(dbi[0]), .ci(dci[0]), .out_valid(ovl[0]), .out_ready(ordy[0]), .y(y0), .x(x0),
        .co(coo[0]), .ov(ovo[0]));
    ql_pipe_addsub #(.WIDTH(13), .STAGE_W(5)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(da[1][12:0]), .b(db[1][12:0]),
        .bi(dbi[1]), .ci(dci[1]), .out_valid(ovl[1]), .out_ready(ordy[1]), .y(y1), .x(x1),
        .co(coo[1]), .ov(ovo[1]));
    ql_pipe_addsub #(.WIDTH(4), .STAGE_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(da[2][3:0]), .b(db[2][3:0]),
        .bi(dbi[2]), .ci(dci[2]), .out_valid(ovl[2]), .out_ready(ordy[2]), .y(y2), .x(x2),
        .co(coo[2]), .ov(ovo[2]));

    function automatic int wd(int d);
        return d == 0 ? 32 : d == 1 ? 13 : 4;
    endfunction
    function automatic int lat(int d);
        return d == 0 ? 4 : d == 1 ? 3 : 1;
    endfunction

    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic bi, logic ci);
        exp_t e;
        logic [32:0] m, s, aa, bb;
        m    = (33'd1 << w) - 33'd1;
        aa   = {1'b0, a} & m;
        bb   = (bi ? ~{1'b0, b} : {1'b0, b}) & m;
        s    = aa + bb + {32'd0, ci};
        e.y  = 32'(s & m);
        e.x  = 32'(aa ^ bb);
        e.co = s[w];
        e.ov = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        e.cyc = cyc;
        return e;
    endfunction

    task automatic check(string tag, logic [71:0] got, logic [71:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(int pin, int pout);
        stim_t st;
        exp_t  e;
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (!pend[d]) begin
                if (d == 0 && stim.size() > 0) begin
                    st     = stim.pop_front();
                    iv[d]  = 1'b1;
                    da[d]  = st.a;
                    db[d]  = st.b;
                    dbi[d] = st.bi;
                    dci[d] = st.ci;
                end else begin
                    iv[d]  = $urandom_range(99) < pin;
                    da[d]  = $urandom;
                    db[d]  = $urandom;
                    dbi[d] = 1'($urandom_range(1));
                    dci[d] = 1'($urandom_range(1));
                end
            end
            ordy[d] = $urandom_range(99) < pout;
        end
        #1;
        if (hold) begin
            check("stall_valid", 72'(ovl[0]), 72'd1);
            check("stall_data", {6'd0, coo[0], ovo[0], xo[0], yo[0]}, held);
        end
        hold = ovl[0] && !ordy[0];
        held = {6'd0, coo[0], ovo[0], xo[0], yo[0]};
        for (int d = 0; d < 3; d++) begin
            check($sformatf("in_ready%0d", d), 72'(ir[d]), 72'(!ovl[d] || ordy[d]));
            if (ovl[d] && ordy[d]) begin
                if (sb[d].size() == 0) check($sformatf("extra%0d", d), 72'(sb[d].size()), 72'd1);
                else begin
                    e = sb[d].pop_front();
                    check($sformatf("result%0d", d), {6'd0, coo[d], ovo[d], xo[d], yo[d]},
                          {6'd0, e.co, e.ov, e.x, e.y});
                    if (b2b) check($sformatf("latency%0d", d), 72'(cyc - e.cyc), 72'(lat(d)));
                end
            end
            if (iv[d] && ir[d]) sb[d].push_back(model(wd(d), da[d], db[d], dbi[d], dci[d]));
            pend[d] = iv[d] && !ir[d];
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb[0].size() + sb[1].size() + sb[2].size() + stim.size() > 0 && n < 40) begin
            step(0, 100);
            n++;
        end
        check("drain", 72'(sb[0].size() + sb[1].size() + sb[2].size()), 72'd0);
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        rst_n = 1'b0;
        iv    = '1;
        for (int d = 0; d < 3; d++) sb[d].delete();
        pend = '0;
        hold = 0;
        for (int c = 0; c <= n; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            for (int d = 0; d < 3; d++)
                check($sformatf("reset%0d", d), {5'd0, ovl[d], coo[d], ovo[d], xo[d], yo[d]}, 72'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        iv    = '0;
        #1;
        check("ready_after_reset", 72'(ir), 72'b111);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset(3);
        stim.push_back('{32'hFFFFFFFF, 32'd1, 1'b0, 1'b0});
        stim.push_back('{32'd5, 32'd7, 1'b1, 1'b1});
        stim.push_back('{32'h80000000, 32'd1, 1'b1, 1'b1});
        repeat (10) step(0, 100);
        drain();
        b2b = 1;
        repeat (100) step(100, 100);
        drain();
        b2b = 0;
        repeat (400) step(50, 50);
        drain();
        repeat (60) step(70, 30);
        do_reset(2);
        repeat (200) step(60, 60);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
